// File: rtl/traffic_light_pkg.sv
// Shared types and lamp patterns for the pedestrian-request traffic light.
// Lamp patterns are ordered {led2, led1, led0} = {green, yellow, red}.
package traffic_light_pkg;

  typedef enum logic [1:0] {
    RED         = 2'd0,
    GREEN       = 2'd1,
    GREEN_BLINK = 2'd2,
    YELLOW      = 2'd3
  } state_e;

  localparam logic [2:0] LED_RED = 3'b001;
  localparam logic [2:0] LED_YEL = 3'b010;
  localparam logic [2:0] LED_GRN = 3'b100;
  localparam logic [2:0] LED_OFF = 3'b000;

endpackage

// File: rtl/btn_sync_edge.sv
// Button synchronizer: two metastability flops, a third flop for history, and a
// single-cycle rising-edge pulse.
module btn_sync_edge (
  input  logic clk,
  input  logic res,
  input  logic btn,
  output logic pulse
);

  logic sync1_q, sync2_q, sync3_q;

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  assign pulse = sync2_q & ~sync3_q;

endmodule

// File: rtl/traffic_light_top.sv
// Pedestrian-request traffic light: rests in RED, runs GREEN -> GREEN_BLINK -> YELLOW
// once per button press, and drives the three lamps from a registered pattern.
module traffic_light_top
  import traffic_light_pkg::*;
#(
  parameter int unsigned MIN_RED_CYCLES = 100,
  parameter int unsigned GREEN_CYCLES   = 500,
  parameter int unsigned BLINK_CYCLES   = 120,
  parameter int unsigned BLINK_HALF     = 20,
  parameter int unsigned YELLOW_CYCLES  = 200,
  parameter int unsigned CNT_W          = 16
) (
  input  logic clk,
  input  logic res,
  input  logic btn,
  output logic led0,
  output logic led1,
  output logic led2
);

  localparam logic [CNT_W-1:0] MIN_RED_LAST = CNT_W'(MIN_RED_CYCLES - 1);
  localparam logic [CNT_W-1:0] GREEN_LAST   = CNT_W'(GREEN_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLINK_LAST   = CNT_W'(BLINK_CYCLES - 1);
  localparam logic [CNT_W-1:0] YELLOW_LAST  = CNT_W'(YELLOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] HALF_LAST    = CNT_W'(BLINK_HALF - 1);
  localparam logic [CNT_W-1:0] CNT_MAX      = '1;

  logic             pulse;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] half_q, half_d;
  logic             req_q, req_d;
  logic [2:0]       led_q, led_d;

  btn_sync_edge u_btn_sync_edge (
    .clk   (clk),
    .res   (res),
    .btn   (btn),
    .pulse (pulse)
  );

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q <= RED;
      cnt_q   <= '0;
      half_q  <= '0;
      req_q   <= 1'b0;
      led_q   <= LED_RED;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      half_q  <= half_d;
      req_q   <= req_d;
      led_q   <= led_d;
    end
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    cnt_d   = cnt_q;
    half_d  = '0;
    led_d   = LED_RED;

    case (state_q)
      RED: begin
        // A pulse in the same cycle the minimum expires is honoured directly.
        if ((req_q || pulse) && cnt_q >= MIN_RED_LAST) begin
          state_d = GREEN;
        end else if (pulse) begin
          req_d = 1'b1;
        end
      end
      GREEN:       if (cnt_q == GREEN_LAST)  state_d = GREEN_BLINK;
      GREEN_BLINK: if (cnt_q == BLINK_LAST)  state_d = YELLOW;
      YELLOW:      if (cnt_q == YELLOW_LAST) state_d = RED;
      default:     state_d = RED;
    endcase

    if (state_d == GREEN && state_q != GREEN) begin
      req_d = 1'b0;
    end

    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end

    // Lamp pattern follows the next state so lamps change on the same edge as the FSM.
    case (state_d)
      RED:    led_d = LED_RED;
      GREEN:  led_d = LED_GRN;
      YELLOW: led_d = LED_YEL;
      GREEN_BLINK: begin
        if (state_q != GREEN_BLINK) begin
          led_d = LED_GRN;
        end else if (half_q == HALF_LAST) begin
          led_d = led_q[2] ? LED_OFF : LED_GRN;
        end else begin
          half_d = half_q + 1'b1;
          led_d  = led_q[2] ? LED_GRN : LED_OFF;
        end
      end
      default: led_d = LED_RED;
    endcase
  end

  assign led0 = led_q[0];
  assign led1 = led_q[1];
  assign led2 = led_q[2];

endmodule

// File: tb/tb_traffic_light_top.sv
// Self-checking bench for traffic_light_top: directed scenarios with literal lamp
// expectations plus randomized button/reset activity against a phase/elapsed model.
module tb_traffic_light_top;

  localparam int MIN_RED = 100;
  localparam int GREEN_N = 500;
  localparam int BLINK_N = 120;
  localparam int HALF    = 20;
  localparam int YEL_N   = 200;

  logic clk = 1'b0;
  logic res;
  logic btn;
  logic led0, led1, led2;

  int errors = 0;
  int checks = 0;

  // Model: phase 0=red 1=green 2=blink 3=yellow, m_el = clocks already spent in phase.
  int m_phase;
  int m_el;
  bit m_pend;
  bit h1, h2, h3;  // btn as sampled 1, 2 and 3 edges ago

  always #5 clk = ~clk;

  traffic_light_top dut (
    .clk  (clk),
    .res  (res),
    .btn  (btn),
    .led0 (led0),
    .led1 (led1),
    .led2 (led2)
  );

  function automatic logic [2:0] model_leds();
    logic [2:0] r;
    case (m_phase)
      0:       r = 3'b001;
      1:       r = 3'b100;
      3:       r = 3'b010;
      default: r = (((m_el / HALF) % 2) == 0) ? 3'b100 : 3'b000;
    endcase
    return r;
  endfunction

  task automatic model_reset();
    m_phase = 0;
    m_el    = 0;
    m_pend  = 0;
    h1 = 0;
    h2 = 0;
    h3 = 0;
  endtask

  task automatic model_edge();
    bit p;
    int dur;
    // A press becomes visible to the controller two edges after it is first sampled.
    p  = h2 & ~h3;
    h3 = h2;
    h2 = h1;
    h1 = btn;
    if (m_phase == 0) begin
      if ((m_pend || p) && m_el >= MIN_RED - 1) begin
        m_phase = 1;
        m_el    = 0;
        m_pend  = 0;
      end else begin
        m_pend = m_pend | p;
        m_el++;
      end
    end else begin
      dur = (m_phase == 1) ? GREEN_N : (m_phase == 2) ? BLINK_N : YEL_N;
      if (m_el == dur - 1) begin
        m_phase = (m_phase + 1) % 4;
        m_el    = 0;
      end else begin
        m_el++;
      end
    end
  endtask

  task automatic check(input string name, input logic [2:0] exp);
    logic [2:0] act;
    act = {led2, led1, led0};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: leds{g,y,r}=%b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (!res) model_reset();
    else model_edge();
    @(negedge clk);
    check("model", model_leds());
  endtask

  // t counts edges from the start of the sequence; btn is high for t in [lo[i], hi[i]].
  task automatic run_seq(input string tag, input int n, input int lo[$], input int hi[$],
                         input int lt[$], input logic [2:0] lv[$]);
    for (int t = 1; t <= n; t++) begin
      bit b;
      b = 0;
      foreach (lo[i]) if (t >= lo[i] && t <= hi[i]) b = 1;
      btn = b;
      step();
      foreach (lt[i]) if (lt[i] == t) check($sformatf("%s t=%0d", tag, t), lv[i]);
    end
    btn = 1'b0;
  endtask

  task automatic pulse_reset(input string name);
    res = 1'b0;
    model_reset();
    #1;
    check(name, 3'b001);
    repeat (2) step();
    res = 1'b1;
  endtask

  initial begin
    int lo[$];
    int hi[$];
    int lt[$];
    logic [2:0] lv[$];
    int len;

    res = 1'b1;
    btn = 1'b0;
    model_reset();
    #2;
    pulse_reset("reset_init");

    // Idle: no press, stays red.
    lo.delete(); hi.delete();
    lt = {500, 1000};
    lv = {3'b001, 3'b001};
    run_seq("idle", 1000, lo, hi, lt, lv);

    // Held press with red minimum elapsed; held past the end of the cycle.
    lo = {1}; hi = {900};
    lt = {1, 2, 3, 502, 503, 522, 523, 622, 623, 822, 823, 1000};
    lv = {3'b001, 3'b001, 3'b100, 3'b100, 3'b100, 3'b100, 3'b000, 3'b000,
          3'b010, 3'b010, 3'b001, 3'b001};
    run_seq("held", 1000, lo, hi, lt, lv);

    // Press 10 clocks after reset: green begins 100 clocks after entering red.
    pulse_reset("reset_s3");
    lo = {11}; hi = {20};
    lt = {99, 100, 599, 600, 719, 720, 919, 920, 1000};
    lv = {3'b001, 3'b100, 3'b100, 3'b100, 3'b000, 3'b010, 3'b010, 3'b001, 3'b001};
    run_seq("early", 1000, lo, hi, lt, lv);

    // Press latched at red counter 80, then presses in green, blink and yellow are ignored.
    lo = {1, 200, 560, 700}; hi = {5, 204, 564, 704};
    lt = {19, 20, 519, 520, 639, 640, 839, 840, 1200};
    lv = {3'b001, 3'b100, 3'b100, 3'b100, 3'b000, 3'b010, 3'b010, 3'b001, 3'b001};
    run_seq("ignored", 1200, lo, hi, lt, lv);

    // Second full cycle, identical timing.
    lo = {1}; hi = {3};
    lt = {2, 3, 502, 503, 523, 623, 822, 823, 900};
    lv = {3'b001, 3'b100, 3'b100, 3'b100, 3'b000, 3'b010, 3'b010, 3'b001, 3'b001};
    run_seq("second", 900, lo, hi, lt, lv);

    // Reset asserted mid-green: lamps go red before the next edge and stay red.
    lo = {1}; hi = {3};
    lt = {22, 23, 100};
    lv = {3'b001, 3'b100, 3'b100};
    run_seq("pre_rst", 100, lo, hi, lt, lv);
    pulse_reset("reset_mid_green");
    lo.delete(); hi.delete();
    lt = {150, 300};
    lv = {3'b001, 3'b001};
    run_seq("post_rst", 300, lo, hi, lt, lv);

    // Randomized button levels with occasional resets.
    for (int r = 0; r < 80; r++) begin
      if ($urandom_range(0, 99) < 4) begin
        pulse_reset("reset_rand");
      end else begin
        btn = 1'($urandom_range(0, 1));
        len = btn ? $urandom_range(1, 900) : $urandom_range(1, 300);
        repeat (len) step();
      end
    end
    btn = 1'b0;
    repeat (5) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/traffic_light_top.md
Name: traffic_light_top

Overview:
Single-intersection pedestrian-request traffic light controller. It rests in RED indefinitely. A button press requests a timed cycle GREEN → GREEN_BLINK → YELLOW, after which it returns to RED. It drives three discrete LEDs directly and is the top level of the traffic-light board design.

Parameters:
MIN_RED_CYCLES, 100, minimum clocks spent in RED before a pending request is honoured
GREEN_CYCLES, 500, clocks of steady green
BLINK_CYCLES, 120, clocks of blinking green
BLINK_HALF, 20, half-period of green blink in clocks (on first)
YELLOW_CYCLES, 200, clocks of yellow
CNT_W, 16, phase counter width; all cycle parameters must be ≤ 2^CNT_W−1 and ≥1

Ports:
clk  input  1  system clock, rising-edge
res  input  1  asynchronous active-low reset
btn  input  1  pedestrian button, asynchronous, active-high, level
led0  output  1  red lamp, active-high
led1  output  1  yellow lamp, active-high
led2  output  1  green lamp, active-high

Behaviour:
- One clock domain clk. Reset res is asynchronous and active-low; all flops clear immediately on res=0 and resume on the first rising clk edge after res=1.
- Reset state: state=RED, counter=0, request=0, synchronizer flops=0. Outputs: led0=1, led1=0, led2=0.
- btn input path: 2-flop synchronizer, then a third flop. The edge pulse is sync2 & ~sync3. Holding btn high gives exactly one pulse, and re-pressing requires btn to be low for ≥1 sampled cycle.
- Request latch: set by an edge pulse while state=RED. Pulses in any other state are ignored and not queued. The latch is cleared on entry to GREEN.
- Phase counter: reset to 0 on every state change, incremented each clock otherwise, saturating at all-ones.
- States and transitions:
  - RED: leave to GREEN when request=1 (or an edge pulse occurs this cycle) and counter ≥ MIN_RED_CYCLES−1.
  - GREEN: after GREEN_CYCLES clocks, go to GREEN_BLINK.
  - GREEN_BLINK: after BLINK_CYCLES clocks, go to YELLOW.
  - YELLOW: after YELLOW_CYCLES clocks, go to RED.
- Illegal state encodings recover to RED on the next clock.
- Outputs are registered and updated on the same edge as the state, so there are no glitches.
  - RED: 100.
  - GREEN: 001.
  - YELLOW: 010.
  - GREEN_BLINK: led2 = ~counter-derived phase, on for BLINK_HALF clocks, then off for BLINK_HALF, repeating; led0=led1=0.
- Exactly one LED or none is lit at any time; never two.
- Latency: btn first sampled high at edge k, with RED minimum already elapsed → LEDs show green after edge k+2.
- Press during the RED minimum period: latched, GREEN starts on the edge where counter reaches MIN_RED_CYCLES−1.
- Button held across the entire cycle: no second cycle starts; a new press after release is needed.
- Reset mid-cycle: immediate return to RED with the request cleared.

Decomposition:
- Shared package traffic_light_pkg:
  - state enum {RED, GREEN, GREEN_BLINK, YELLOW} (2-bit)
  - LED pattern constants LED_RED=3'b001, LED_YEL=3'b010, LED_GRN=3'b100, as {led2,led1,led0}
- One sub-module: btn_sync_edge (3-flop synchronizer plus rising-edge pulse, async active-low reset).
- FSM, counter and output register stay in the top.

Test Plan:
- Reset pulse res 1→0→1 with btn=0 for 1000 clocks → led0=1, led1=0, led2=0 throughout; no transition.
- After ≥100 clocks in RED, btn high for 700 clocks → green at edge k+2. Sequence must be 500 clocks green, then 120 clocks blinking (on 20 / off 20, 3 periods), then 200 yellow, then red. Press held past the end must not restart the cycle.
- Press 10 clocks after reset → GREEN begins at RED counter=99, i.e. 100 clocks after entering RED.
- Press during GREEN, BLINK and YELLOW (pulse 5 clocks each) → ignored; after YELLOW the light stays RED.
- Second press (btn low ≥1 clock between presses) after return to RED → a full second cycle with identical timing.
- Assert res low mid-GREEN → LEDs 100 immediately (asynchronously, before the next clk edge); the FSM stays in RED without a new press.
